// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, slave FSM states and the address-window check.
package wb_pkg;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;
   localparam int unsigned WB_SEL_W = 4;

   typedef enum logic [1:0] {
      WB_S_IDLE,
      WB_S_WAIT,
      WB_S_RESP
   } wb_slv_state_t;

   // True when adr is word aligned and falls inside [base, base + depth*4).
   function automatic logic wb_addr_ok(input logic [WB_ADR_W-1:0] adr,
                                       input logic [WB_ADR_W-1:0] base,
                                       input int unsigned         depth);
      logic [WB_ADR_W:0] off;
      logic [WB_ADR_W:0] lim;
      off = {1'b0, adr} - {1'b0, base};
      lim = (WB_ADR_W + 1)'(depth) << 2;
      return (adr[1:0] == 2'b00) && (adr >= base) && (off < lim);
   endfunction

endpackage

// File: rtl/wb_sram_core.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module wb_sram_core import wb_pkg::*; #(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [WB_SEL_W-1:0] be,
   input  logic [AW-1:0]       addr,
   input  logic [WB_DAT_W-1:0] wdata,
   output logic [WB_DAT_W-1:0] rdata
);

   logic [WB_DAT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(WB_SEL_W); i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      rdata <= mem[addr];
   end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic slave fronting a byte-lane SRAM, with optional wait states and err.
module wb_sram_slave import wb_pkg::*; #(
   parameter int unsigned         DEPTH       = 1024,
   parameter int unsigned         WAIT_STATES = 0,
   parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [WB_ADR_W-1:0] wb_adr_i,
   input  logic [WB_DAT_W-1:0] wb_dat_i,
   input  logic [WB_SEL_W-1:0] wb_sel_i,
   output logic [WB_DAT_W-1:0] wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   wb_slv_state_t       state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WB_ADR_W-1:0] adr_q;
   logic [WB_DAT_W-1:0] wdat_q;
   logic [WB_SEL_W-1:0] sel_q;
   logic                we_q;
   logic                ack_q;
   logic                err_q;
   logic [WB_DAT_W-1:0] rdat_q;

   logic                addr_ok;
   logic [WB_ADR_W-1:0] ram_adr;
   logic [WB_ADR_W-1:0] ram_off;
   logic [AW-1:0]       ram_idx;
   logic                ram_we;
   logic [WB_DAT_W-1:0] ram_rdata;

   assign addr_ok = wb_addr_ok(adr_q, BASE_ADDR, DEPTH);

   // The RAM read is issued on the edge entering RESP; with no wait states that edge is the
   // capture edge itself, so the live bus address feeds the RAM while idle.
   assign ram_adr = (state_q == WB_S_IDLE) ? wb_adr_i : adr_q;
   assign ram_off = ram_adr - BASE_ADDR;
   assign ram_idx = AW'(ram_off >> 2);
   assign ram_we  = (state_q == WB_S_RESP) && we_q && addr_ok;

   wb_sram_core #(
      .DEPTH (DEPTH)
   ) u_core (
      .clk   (clk),
      .we    (ram_we),
      .be    (sel_q),
      .addr  (ram_idx),
      .wdata (wdat_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WB_S_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         rdat_q <= '0;
         unique case (state_q)
            WB_S_IDLE: begin
               cnt_q <= CNT_RELOAD;
               // A held strobe must not be re-accepted while its own ack/err is on the bus.
               if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                  adr_q   <= wb_adr_i;
                  wdat_q  <= wb_dat_i;
                  sel_q   <= wb_sel_i;
                  we_q    <= wb_we_i;
                  state_q <= (WAIT_STATES > 0) ? WB_S_WAIT : WB_S_RESP;
               end
            end
            WB_S_WAIT: begin
               if (!wb_cyc_i) begin
                  state_q <= WB_S_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= WB_S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WB_S_RESP: begin
               ack_q   <= addr_ok;
               err_q   <= !addr_ok;
               rdat_q  <= (addr_ok && !we_q) ? ram_rdata : '0;
               state_q <= WB_S_IDLE;
            end
            default: state_q <= WB_S_IDLE;
         endcase
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = rdat_q;

endmodule
